// File: rtl/sos_module_if.sv
// SOS beacon control/status bundle: trigger in, buzzer and status out.
interface sos_module_if;
  logic SOS_En_Sig;
  logic Pin_Out;
  logic Busy_Sig;
  logic Done_Sig;

  // Sequencer side
  modport slave (
    input  SOS_En_Sig,
    output Pin_Out,
    output Busy_Sig,
    output Done_Sig
  );

  // Trigger source / observer side
  modport master (
    output SOS_En_Sig,
    input  Pin_Out,
    input  Busy_Sig,
    input  Done_Sig
  );
endinterface

// File: rtl/sos_module.sv
// SOS beacon sequencer: plays ... --- ... on a buzzer pin after a trigger pulse.
// Nine symbols, each a tone followed by a fixed gap; timing derived from a
// millisecond tick that only runs while a sequence is active.
module sos_module #(
  parameter logic [15:0] T1MS    = 16'd49_999,
  parameter logic [9:0]  DOT_MS  = 10'd100,
  parameter logic [9:0]  DASH_MS = 10'd300,
  parameter logic [9:0]  GAP_MS  = 10'd100
) (
  input logic        CLK,
  input logic        RST,
  sos_module_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_idx;
  logic [3:0]  w_idx_next;
  logic [15:0] r_cyc;
  logic [15:0] w_cyc_next;
  logic [9:0]  r_ms;
  logic [9:0]  w_ms_next;
  logic        w_done_next;
  logic        r_pin;
  logic        r_busy;
  logic        r_done;

  logic        w_tick;
  logic [9:0]  w_sym_ms;
  logic        w_tone_end;
  logic        w_gap_end;

  // Symbols 3..5 are the dashes; the rest are dots.
  assign w_sym_ms   = ((r_idx >= 4'd3) && (r_idx <= 4'd5)) ? DASH_MS : DOT_MS;
  assign w_tick     = (r_cyc == T1MS);
  // A phase ends on the tick that completes its last millisecond.
  assign w_tone_end = w_tick && (r_ms == (w_sym_ms - 10'd1));
  assign w_gap_end  = w_tick && (r_ms == (GAP_MS - 10'd1));

  // Next-state, symbol index and completion decode.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        w_idx_next = 4'd0;
        if (bus.SOS_En_Sig) begin
          w_state_next = TONE;
        end
      end
      TONE: begin
        if (w_tone_end) begin
          w_state_next = GAP;
        end
      end
      GAP: begin
        if (w_gap_end) begin
          if (r_idx == 4'd8) begin
            w_state_next = IDLE;
            w_idx_next   = 4'd0;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = TONE;
            w_idx_next   = r_idx + 4'd1;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_idx_next   = 4'd0;
      end
    endcase
  end

  // Cycle and millisecond counters; both parked at zero while idle.
  // Phase ends always coincide with a cycle-counter wrap, so only the ms
  // counter needs an explicit clear on a phase change.
  always_comb begin
    w_cyc_next = 16'd0;
    w_ms_next  = 10'd0;
    if (r_state != IDLE) begin
      w_cyc_next = w_tick ? 16'd0 : (r_cyc + 16'd1);
      if (w_state_next == r_state) begin
        w_ms_next = w_tick ? (r_ms + 10'd1) : r_ms;
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_idx   <= 4'd0;
      r_cyc   <= 16'd0;
      r_ms    <= 10'd0;
      r_pin   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_cyc   <= w_cyc_next;
      r_ms    <= w_ms_next;
      r_pin   <= (w_state_next == TONE);
      r_busy  <= (w_state_next != IDLE);
      r_done  <= w_done_next;
    end
  end

  assign bus.Pin_Out  = r_pin;
  assign bus.Busy_Sig = r_busy;
  assign bus.Done_Sig = r_done;

endmodule

// File: tb/tb_sos_module.sv
// Self-checking bench for sos_module with shortened timing
// (dot 20, dash 60, gap 20 clock cycles).
module tb_sos_module;

  localparam logic [15:0] T1MS    = 16'd9;
  localparam logic [9:0]  DOT_MS  = 10'd2;
  localparam logic [9:0]  DASH_MS = 10'd6;
  localparam logic [9:0]  GAP_MS  = 10'd2;
  localparam int CPM      = 10;          // cycles per ms
  localparam int DOT_CYC  = 2 * CPM;
  localparam int DASH_CYC = 6 * CPM;
  localparam int GAP_CYC  = 2 * CPM;
  localparam int SEQ_LEN  = 6 * (DOT_CYC + GAP_CYC) + 3 * (DASH_CYC + GAP_CYC); // 480

  logic CLK;
  logic RST;

  sos_module_if bus ();

  sos_module #(
    .T1MS    (T1MS),
    .DOT_MS  (DOT_MS),
    .DASH_MS (DASH_MS),
    .GAP_MS  (GAP_MS)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard of expected {Pin_Out, Busy_Sig, Done_Sig} for the next cycle.
  logic [2:0] exp_q[$];

  // Model position: 0 = idle, 1..SEQ_LEN = inside sequence, SEQ_LEN+1 = done cycle.
  int m_t = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Expected outputs at sequence position t.
  function automatic logic [2:0] exp_out(input int t);
    int pos;
    int len;
    if (t == 0) return 3'b000;
    if (t == SEQ_LEN + 1) return 3'b001;
    pos = t - 1;
    for (int s = 0; s < 9; s++) begin
      len = (s >= 3 && s <= 5) ? DASH_CYC : DOT_CYC;
      if (pos < len) return 3'b110;
      pos -= len;
      if (pos < GAP_CYC) return 3'b010;
      pos -= GAP_CYC;
    end
    return 3'b000;
  endfunction

  // Drive one cycle of inputs, push the expectation, then compare after the edge.
  task automatic run_cycle(input logic rst, input logic trig, input bit chk_cnt);
    logic [2:0] got;
    logic [2:0] want;
    RST            = rst;
    bus.SOS_En_Sig = trig;
    if (rst) begin
      m_t = 0;
    end else if (m_t == 0 || m_t == SEQ_LEN + 1) begin
      m_t = trig ? 1 : 0;
    end else begin
      m_t = m_t + 1;
    end
    exp_q.push_back(exp_out(m_t));
    @(posedge CLK);
    #1;
    RST            = 1'b0;
    bus.SOS_En_Sig = 1'b0;
    @(negedge CLK);
    got  = {bus.Pin_Out, bus.Busy_Sig, bus.Done_Sig};
    want = exp_q.pop_front();
    check("pin_busy_done", {29'd0, got}, {29'd0, want});
    if (chk_cnt) check("cyc_cnt_idle", {16'd0, dut.r_cyc}, 32'd0);
  endtask

  initial begin
    RST            = 1'b1;
    bus.SOS_En_Sig = 1'b0;

    // Idle/reset quiet: reset for 5 cycles, a stray trigger under reset, then 995 idle.
    for (int c = 0; c < 1000; c++) begin
      run_cycle(c < 5, (c == 2), 1'b1);
    end
    $display("scenario idle_quiet done: compared=%0d mismatched=%0d", n_cmp, n_err);

    // Single trigger.
    for (int c = 0; c < 490; c++) begin
      run_cycle(1'b0, (c == 0), 1'b0);
    end
    $display("scenario single_trigger done: compared=%0d mismatched=%0d", n_cmp, n_err);

    // Retrigger while busy must be ignored.
    for (int c = 0; c < 490; c++) begin
      run_cycle(1'b0, (c == 0 || c == 50 || c == 300 || c == 480), 1'b0);
    end
    $display("scenario retrigger_busy done: compared=%0d mismatched=%0d", n_cmp, n_err);

    // Back-to-back: second trigger in the Done cycle.
    for (int c = 0; c < 975; c++) begin
      run_cycle(1'b0, (c == 0 || c == SEQ_LEN + 1), 1'b0);
    end
    $display("scenario back_to_back done: compared=%0d mismatched=%0d", n_cmp, n_err);

    // Reset mid-dash (with a trigger during reset), then a fresh full sequence.
    for (int c = 0; c < 200; c++) begin
      run_cycle((c == 150), (c == 0 || c == 150), 1'b0);
    end
    for (int c = 0; c < 490; c++) begin
      run_cycle(1'b0, (c == 0), 1'b0);
    end
    $display("scenario reset_mid_dash done: compared=%0d mismatched=%0d", n_cmp, n_err);

    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
